// File: rtl/sic_pkg.sv
// Shared types and helpers for the SIC frame controller.
// Contents: state enum, default data width, bit-counter width function.
// Optional build macro used by the design: SIC_PARITY_EN (adds even parity bit).
package sic_pkg;

  localparam int unsigned SIC_NBITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } sic_state_e;

  // Counter must be able to hold the value NBITS.
  function automatic int unsigned sic_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sic_frame_ctrl_if.sv
// Downstream word handshake bundle of the SIC frame controller.
// Signals: word (captured data), word_valid (word available), word_ready (sink accepts).
// master = controller side, slave = consumer side.
interface sic_frame_ctrl_if
  import sic_pkg::*;
#(
  parameter int unsigned NBITS = SIC_NBITS_DEFAULT
);

  logic [NBITS-1:0] word;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output word,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/sic_word_reg.sv
// Output holding register: owns the captured word, its valid flag and the sticky
// overrun flag.
// Ports: clk, rst (sync, active-high); capture (good frame this edge), din (SIC
// parallel data), ready (downstream accepts), ovr_clr (clear overrun);
// word, word_valid, overrun (all registered).
module sic_word_reg
  import sic_pkg::*;
#(
  parameter int unsigned NBITS = SIC_NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [NBITS-1:0] din,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [NBITS-1:0] word,
  output logic             word_valid,
  output logic             overrun
);

  logic [NBITS-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;
  logic             load_c;
  logic             ovr_set_c;

  // A new word may replace the old one only if the old one is gone or leaving now.
  always_comb begin
    load_c       = capture && (!word_valid_q || ready);
    ovr_set_c    = capture && word_valid_q && !ready;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    if (load_c) begin
      word_d       = din;
      word_valid_d = 1'b1;
    end else if (word_valid_q && ready) begin
      word_valid_d = 1'b0;
    end

    // Set has priority over clear.
    if (ovr_set_c) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/sic_frame_ctrl.sv
// Frame controller for the serial-input converter: detects a start bit on p,
// enables the SIC shift for NBITS cycles, checks (optional parity and) the stop
// bit, and hands good words downstream through a valid/ready bundle.
// Ports: clk, rst (sync, active-high); p (serial line, idle 0); sic_q (SIC
// parallel output, first bit in MSB); shift_en (combinational, DATA only);
// busy, frame_err, par_err, overrun (registered); ovr_clr (clear overrun);
// wb (master side of sic_frame_ctrl_if: word, word_valid, word_ready).
// Build macro: SIC_PARITY_EN adds an even-parity bit after the data bits.
module sic_frame_ctrl
  import sic_pkg::*;
#(
  parameter int unsigned NBITS = SIC_NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p,
  input  logic [NBITS-1:0] sic_q,
  output logic             shift_en,
  output logic             busy,
  output logic             frame_err,
  output logic             par_err,
  output logic             overrun,
  input  logic             ovr_clr,
  sic_frame_ctrl_if.master wb
);

  localparam int unsigned CNT_W = sic_cnt_width(NBITS);

  sic_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             capture_c;
  logic [NBITS-1:0] word_o;
  logic             word_valid_o;

`ifdef SIC_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             par_err_q, par_err_d;
`endif

  // Next-state and pulse generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    capture_c   = 1'b0;
`ifdef SIC_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (p) begin
          state_d   = DATA;
          cnt_d     = '0;
`ifdef SIC_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end

      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NBITS - 1)) begin
`ifdef SIC_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end

`ifdef SIC_PARITY_EN
      // Even parity: data bits plus parity bit must XOR to 0.
      PARITY: begin
        par_bad_d = ^{sic_q, p};
        par_err_d = ^{sic_q, p};
        state_d   = STOP;
      end
`endif

      // A 1 here is a framing error, never a new start bit.
      STOP: begin
        frame_err_d = p;
`ifdef SIC_PARITY_EN
        capture_c   = !p && !par_bad_q;
`else
        capture_c   = !p;
`endif
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SIC_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef SIC_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  sic_word_reg #(
    .NBITS (NBITS)
  ) u_word_reg (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture_c),
    .din        (sic_q),
    .ready      (wb.word_ready),
    .ovr_clr    (ovr_clr),
    .word       (word_o),
    .word_valid (word_valid_o),
    .overrun    (overrun)
  );

  // SIC must not shift while reset is held.
  assign shift_en      = (state_q == DATA) && !rst;
  assign busy          = busy_q;
  assign frame_err     = frame_err_q;
  assign wb.word       = word_o;
  assign wb.word_valid = word_valid_o;

`ifdef SIC_PARITY_EN
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sic_frame_ctrl.sv
// Bench for sic_frame_ctrl: models the SIC, tracks each frame by its cycle
// position, and compares every output on every cycle.
module tb_sic_frame_ctrl;
  import sic_pkg::*;

  localparam int unsigned NB = SIC_NBITS_DEFAULT;
`ifdef SIC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          p       = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [NB-1:0] sic_q   = '0;
  logic          shift_en, busy, frame_err, par_err, overrun;
  bit            chk_en  = 1'b0;
  int            checks  = 0;
  int            errors  = 0;

  sic_frame_ctrl_if #(.NBITS(NB)) bus ();

  sic_frame_ctrl #(.NBITS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .p         (p),
    .sic_q     (sic_q),
    .shift_en  (shift_en),
    .busy      (busy),
    .frame_err (frame_err),
    .par_err   (par_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .wb        (bus.master)
  );

  always #5 clk = ~clk;

  // External SIC: shifts left, first serial bit ends in the MSB.
  always @(posedge clk) if (shift_en) sic_q <= {sic_q[NB-2:0], p};

  // Reference model: k is the position of the current cycle within a frame
  // (-1 = idle, 1..NB data bits, then optional parity, then stop).
  int            k         = -1;
  int            data      = 0;
  bit            m_valid   = 0;
  bit            m_ovr     = 0;
  bit            m_ferr    = 0;
  bit            m_perr    = 0;
  bit            m_par_bad = 0;
  logic [NB-1:0] m_word    = '0;

  always @(posedge clk) begin : model
    bit good;
    bit ovr_set;
    good    = 0;
    ovr_set = 0;
    if (rst) begin
      k = -1; data = 0; m_valid = 0; m_ovr = 0;
      m_ferr = 0; m_perr = 0; m_par_bad = 0; m_word = '0;
    end else begin
      m_ferr = 0;
      m_perr = 0;
      if (k < 0) begin
        if (p) begin k = 1; data = 0; m_par_bad = 0; end
      end else if (k <= int'(NB)) begin
        data = (data << 1) | int'(p);
        k++;
      end else if (PAR == 1 && k == int'(NB) + 1) begin
        m_par_bad = (^(NB'(data))) ^ p;
        m_perr    = m_par_bad;
        k++;
      end else begin
        m_ferr = p;
        good   = !p && !m_par_bad;
        k      = -1;
      end
      if (good) begin
        if (!m_valid || bus.word_ready) begin
          m_word  = NB'(data);
          m_valid = 1;
        end else begin
          ovr_set = 1;
        end
      end else if (m_valid && bus.word_ready) begin
        m_valid = 0;
      end
      if (ovr_set) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("word_valid", 32'(bus.word_valid), 32'(m_valid));
      chk("word",       32'(bus.word),       32'(m_word));
      chk("busy",       32'(busy),           32'(k != -1));
      chk("frame_err",  32'(frame_err),      32'(m_ferr));
      chk("par_err",    32'(par_err),        32'(m_perr));
      chk("overrun",    32'(overrun),        32'(m_ovr));
      chk("shift_en",   32'(shift_en),       32'(k >= 1 && k <= int'(NB) && !rst));
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the sampling edge.
  task automatic step(input logic pv, input logic rdy = 1'b0,
                      input logic clr = 1'b0, input logic rs = 1'b0);
    p = pv; bus.word_ready = rdy; ovr_clr = clr; rst = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [NB-1:0] d, input logic pb,
                            input logic stop, input logic rdy_stop);
    step(1'b1);
    for (int i = int'(NB) - 1; i >= 0; i--) step(d[i]);
    if (PAR == 1) step(pb);
    step(stop, rdy_stop);
  endtask

  initial begin
    bus.word_ready = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(bus.word_valid), 32'd0);
    step(1'b0); step(1'b0);

    // Good frame 1010: valid appears only after the stop bit.
    step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    chk("lat_valid_low", 32'(bus.word_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    if (PAR == 1) step(1'b0);
    step(1'b0);
    chk("lit_word_1010", 32'(bus.word), 32'hA);
    chk("lit_valid", 32'(bus.word_valid), 32'd1);
    chk("lit_ferr0", 32'(frame_err), 32'd0);
    step(1'b0, 1'b1);
    chk("drain_valid", 32'(bus.word_valid), 32'd0);

    // Bad stop bit: error pulse, no word, no restart on the stop 1.
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
    chk("lit_ferr_pulse", 32'(frame_err), 32'd1);
    chk("lit_ferr_novalid", 32'(bus.word_valid), 32'd0);
    chk("lit_ferr_idle", 32'(busy), 32'd0);
    step(1'b0);
    chk("lit_ferr_once", 32'(frame_err), 32'd0);
    chk("lit_no_restart", 32'(busy), 32'd0);

    // Two frames with no ready: first word held, overrun set, then cleared.
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
    chk("lit_held_word", 32'(bus.word), 32'h3);
    chk("lit_overrun", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("lit_ovr_clr", 32'(overrun), 32'd0);

    // Ready on the completing edge: word replaced, valid held, no overrun.
    send_frame(4'b0110, 1'b0, 1'b0, 1'b1);
    chk("lit_swap_word", 32'(bus.word), 32'h6);
    chk("lit_swap_valid", 32'(bus.word_valid), 32'd1);
    chk("lit_swap_ovr", 32'(overrun), 32'd0);
    step(1'b0, 1'b1);

    // Reset in the middle of DATA, then a clean frame.
    send_frame(4'b1111, 1'b0, 1'b0, 1'b0);
    step(1'b1); step(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_valid", 32'(bus.word_valid), 32'd0);
    chk("lit_rst_word", 32'(bus.word), 32'd0);
    chk("lit_rst_shift", 32'(shift_en), 32'd0);
    step(1'b0);
    send_frame(4'b1001, 1'b0, 1'b0, 1'b0);
    chk("lit_post_rst_word", 32'(bus.word), 32'h9);
    step(1'b0, 1'b1);

`ifdef SIC_PARITY_EN
    // Odd total parity is rejected even with a good stop bit.
    step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    step(1'b1);
    chk("lit_par_err", 32'(par_err), 32'd1);
    step(1'b0);
    chk("lit_par_novalid", 32'(bus.word_valid), 32'd0);
    chk("lit_par_once", 32'(par_err), 32'd0);
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
    chk("lit_par_good", 32'(bus.word), 32'hA);
    step(1'b0, 1'b1);
`endif

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 5),
           1'($urandom_range(0, 199) == 0));
    end
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    for (int n = 0; n < int'(NB) + 4; n++) step(1'b0, 1'b1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
